// File: rtl/mmio_feedback_unit.sv
// Per-channel MMIO loopback: returns each core output as direct, delayed,
// held or change-counted data, plus a sticky "value changed" flag per channel.
module mmio_feedback_unit #(
    parameter int NUM_PORTS = 8,
    parameter int WIDTH     = 32,
    parameter int DELAY     = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_PORTS*WIDTH-1:0] mmio_out,
    output logic [NUM_PORTS*WIDTH-1:0] mmio_in,
    input  logic [NUM_PORTS*2-1:0]     mode,
    input  logic [NUM_PORTS-1:0]       capture,
    input  logic [NUM_PORTS-1:0]       clear,
    output logic [NUM_PORTS-1:0]       changed
);

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_DELAY  = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;
    localparam logic [1:0] MODE_COUNT  = 2'b11;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ch
        logic [WIDTH-1:0] w_out;
        logic [1:0]       w_mode;
        logic             w_diff;
        logic [WIDTH-1:0] w_sel;
        logic [WIDTH-1:0] r_dly [DELAY];
        logic [WIDTH-1:0] r_hold;
        logic [WIDTH-1:0] r_prev;
        logic [WIDTH-1:0] r_cnt;
        logic             r_chg;

        assign w_out  = mmio_out[g*WIDTH +: WIDTH];
        assign w_mode = mode[2*g +: 2];
        assign w_diff = (w_out != r_prev);

        // The delay line runs in every mode so entering delayed mode shows real history.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                for (int k = 0; k < DELAY; k++) begin
                    r_dly[k] <= '0;
                end
            end else begin
                r_dly[0] <= w_out;
                for (int k = 1; k < DELAY; k++) begin
                    r_dly[k] <= r_dly[k-1];
                end
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_hold <= '0;
                r_prev <= '0;
            end else begin
                r_prev <= w_out;
                if (capture[g]) begin
                    r_hold <= w_out;
                end
            end
        end

        // Clear has priority over a same-edge change; the counter saturates at all-ones.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_cnt <= '0;
                r_chg <= 1'b0;
            end else if (clear[g]) begin
                r_cnt <= '0;
                r_chg <= 1'b0;
            end else begin
                if (w_diff) begin
                    r_chg <= 1'b1;
                end
                if (w_diff && (w_mode == MODE_COUNT) && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + WIDTH'(1);
                end
            end
        end

        always_comb begin
            w_sel = w_out;
            case (w_mode)
                MODE_DIRECT: w_sel = w_out;
                MODE_DELAY:  w_sel = r_dly[DELAY-1];
                MODE_HOLD:   w_sel = r_hold;
                MODE_COUNT:  w_sel = r_cnt;
                default:     w_sel = w_out;
            endcase
        end

        assign mmio_in[g*WIDTH +: WIDTH] = w_sel;
        assign changed[g]                = r_chg;
    end

endmodule

// File: tb/tb_mmio_feedback_unit.sv
// Directed self-checking bench for mmio_feedback_unit: a 32-bit/DELAY=3 instance
// for most features and a 2-bit instance for counter saturation.
module tb_mmio_feedback_unit;

    logic         clock;
    logic         reset;

    logic [255:0] a_out;
    logic [255:0] a_in;
    logic [15:0]  a_mode;
    logic [7:0]   a_cap;
    logic [7:0]   a_clr;
    logic [7:0]   a_chg;

    logic [7:0]   b_out;
    logic [7:0]   b_in;
    logic [7:0]   b_mode;
    logic [3:0]   b_cap;
    logic [3:0]   b_clr;
    logic [3:0]   b_chg;

    int checks;
    int errors;

    mmio_feedback_unit #(.NUM_PORTS(8), .WIDTH(32), .DELAY(3)) dut_a (
        .clock    (clock),
        .reset    (reset),
        .mmio_out (a_out),
        .mmio_in  (a_in),
        .mode     (a_mode),
        .capture  (a_cap),
        .clear    (a_clr),
        .changed  (a_chg)
    );

    mmio_feedback_unit #(.NUM_PORTS(4), .WIDTH(2), .DELAY(1)) dut_b (
        .clock    (clock),
        .reset    (reset),
        .mmio_out (b_out),
        .mmio_in  (b_in),
        .mode     (b_mode),
        .capture  (b_cap),
        .clear    (b_clr),
        .changed  (b_chg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_a(input int ch, input logic [31:0] v);
        a_out[ch*32 +: 32] = v;
    endtask

    task automatic set_a_mode(input int ch, input logic [1:0] m);
        a_mode[ch*2 +: 2] = m;
    endtask

    function automatic logic [31:0] get_a(input int ch);
        return a_in[ch*32 +: 32];
    endfunction

    task automatic test_reset();
        reset  = 1'b0;
        a_out  = '0;
        a_mode = '0;
        a_cap  = '0;
        a_clr  = '0;
        b_out  = '0;
        b_mode = '0;
        b_cap  = '0;
        b_clr  = '0;
        set_a(0, 32'hDEADBEEF);
        set_a(1, 32'h11111111);
        set_a(2, 32'h22222222);
        set_a(3, 32'h33333333);
        set_a_mode(1, 2'b01);
        set_a_mode(2, 2'b10);
        set_a_mode(3, 2'b11);
        a_cap[2] = 1'b1;
        step();
        step();
        checks++;
        if (get_a(0) !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rst_passthru got %h want deadbeef", get_a(0));
        end
        for (int ch = 1; ch < 4; ch++) begin
            checks++;
            if (get_a(ch) !== 32'h0) begin
                errors++;
                $display("FAIL rst_zero_ch%0d got %h want 0", ch, get_a(ch));
            end
        end
        checks++;
        if (a_chg !== 8'h00) begin
            errors++;
            $display("FAIL rst_changed got %h want 00", a_chg);
        end
        a_cap = '0;
        set_a(1, 32'h0);
        set_a(2, 32'h0);
        set_a(3, 32'h0);
        reset = 1'b1;
        step();
        checks++;
        if (get_a(0) !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL post_rst_passthru got %h want deadbeef", get_a(0));
        end
    endtask

    task automatic test_direct();
        set_a(0, 32'h12345678);
        #1;
        checks++;
        if (get_a(0) !== 32'h12345678) begin
            errors++;
            $display("FAIL direct got %h want 12345678", get_a(0));
        end
    endtask

    task automatic test_delay();
        logic [31:0] exp_v [7];
        exp_v = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (get_a(1) !== exp_v[i]) begin
                errors++;
                $display("FAIL delay_step%0d got %h want %h", i, get_a(1), exp_v[i]);
            end
            if (i < 4) set_a(1, 32'(i + 1));
            step();
        end
    endtask

    task automatic test_hold();
        set_a(2, 32'h55);
        a_cap[2] = 1'b1;
        step();
        a_cap[2] = 1'b0;
        set_a(2, 32'hAA);
        checks++;
        if (get_a(2) !== 32'h55) begin
            errors++;
            $display("FAIL hold_load got %h want 55", get_a(2));
        end
        step();
        step();
        checks++;
        if (get_a(2) !== 32'h55) begin
            errors++;
            $display("FAIL hold_keep got %h want 55", get_a(2));
        end
        set_a_mode(2, 2'b00);
        set_a(2, 32'h77);
        a_cap[2] = 1'b1;
        step();
        a_cap[2] = 1'b0;
        set_a_mode(2, 2'b10);
        #1;
        checks++;
        if (get_a(2) !== 32'h77) begin
            errors++;
            $display("FAIL hold_other_mode got %h want 77", get_a(2));
        end
    endtask

    task automatic test_count_hold();
        set_a(3, 32'h5);
        step();
        checks++;
        if (get_a(3) !== 32'd1) begin
            errors++;
            $display("FAIL cnt_first got %h want 1", get_a(3));
        end
        set_a_mode(3, 2'b00);
        set_a(3, 32'h6);
        step();
        set_a_mode(3, 2'b11);
        #1;
        checks++;
        if (get_a(3) !== 32'd1) begin
            errors++;
            $display("FAIL cnt_hold_offmode got %h want 1", get_a(3));
        end
        set_a(3, 32'h7);
        step();
        checks++;
        if (get_a(3) !== 32'd2 || a_chg[3] !== 1'b1) begin
            errors++;
            $display("FAIL cnt_resume got %h/%b want 2/1", get_a(3), a_chg[3]);
        end
    endtask

    task automatic test_count_sat();
        logic [1:0] exp_c [5];
        exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        b_mode[7:6] = 2'b11;
        for (int i = 0; i < 5; i++) begin
            b_out[7:6] = (i % 2 == 0) ? 2'd1 : 2'd0;
            step();
            checks++;
            if (b_in[7:6] !== exp_c[i]) begin
                errors++;
                $display("FAIL sat_step%0d got %0d want %0d", i, b_in[7:6], exp_c[i]);
            end
        end
        checks++;
        if (b_chg[3] !== 1'b1) begin
            errors++;
            $display("FAIL sat_changed got %b want 1", b_chg[3]);
        end
        b_clr[3] = 1'b1;
        step();
        b_clr[3] = 1'b0;
        checks++;
        if (b_in[7:6] !== 2'd0 || b_chg[3] !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear got %0d/%b want 0/0", b_in[7:6], b_chg[3]);
        end
    endtask

    task automatic test_clear_vs_set();
        set_a_mode(4, 2'b11);
        set_a(4, 32'h9);
        step();
        checks++;
        if (get_a(4) !== 32'd1 || a_chg[4] !== 1'b1) begin
            errors++;
            $display("FAIL clr_setup got %h/%b want 1/1", get_a(4), a_chg[4]);
        end
        set_a(4, 32'hA);
        a_clr[4] = 1'b1;
        step();
        a_clr[4] = 1'b0;
        checks++;
        if (get_a(4) !== 32'd0 || a_chg[4] !== 1'b0) begin
            errors++;
            $display("FAIL clr_wins got %h/%b want 0/0", get_a(4), a_chg[4]);
        end
        set_a(4, 32'hB);
        step();
        checks++;
        if (get_a(4) !== 32'd1 || a_chg[4] !== 1'b1) begin
            errors++;
            $display("FAIL clr_then_set got %h/%b want 1/1", get_a(4), a_chg[4]);
        end
    endtask

    task automatic test_capture_clear();
        set_a_mode(5, 2'b10);
        set_a(5, 32'h33);
        a_cap[5] = 1'b1;
        a_clr[5] = 1'b1;
        step();
        a_cap[5] = 1'b0;
        a_clr[5] = 1'b0;
        checks++;
        if (get_a(5) !== 32'h33 || a_chg[5] !== 1'b0) begin
            errors++;
            $display("FAIL cap_clr got %h/%b want 33/0", get_a(5), a_chg[5]);
        end
        checks++;
        if (a_chg[7:6] !== 2'b00 || get_a(6) !== 32'h0) begin
            errors++;
            $display("FAIL independent got %b/%h want 00/0", a_chg[7:6], get_a(6));
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b0;
        #1;
        for (int ch = 1; ch < 6; ch++) begin
            checks++;
            if (get_a(ch) !== 32'h0) begin
                errors++;
                $display("FAIL mid_rst_ch%0d got %h want 0", ch, get_a(ch));
            end
        end
        checks++;
        if (a_chg !== 8'h00 || b_chg !== 4'h0) begin
            errors++;
            $display("FAIL mid_rst_changed got %h/%h want 00/0", a_chg, b_chg);
        end
        checks++;
        if (get_a(0) !== 32'h12345678) begin
            errors++;
            $display("FAIL mid_rst_passthru got %h want 12345678", get_a(0));
        end
        step();
        reset = 1'b1;
        step();
        checks++;
        if (get_a(3) !== 32'd1 || a_chg[3] !== 1'b1) begin
            errors++;
            $display("FAIL post_rst_prev0 got %h/%b want 1/1", get_a(3), a_chg[3]);
        end
        checks++;
        if (get_a(1) !== 32'h0) begin
            errors++;
            $display("FAIL post_rst_delay got %h want 0", get_a(1));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_direct();
        test_delay();
        test_hold();
        test_count_hold();
        test_count_sat();
        test_clear_vs_set();
        test_capture_clear();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
